branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- ID-stage branch/jump resolution unit for the pipelined MIPS core; the parametrised successor of the current branch/jump check block.
- Evaluates all six conditional branch types plus J/JAL/JR and corrects the IF-stage static prediction.
- Issues a registered, handshaked redirect to the fetch unit, flushes the wrong-path IF/ID entry and stalls ID while operands are unresolved.

Parameters:
- D_WIDTH, 32, datapath/PC width; must be >= 28.
- CNT_W, 16, width of the performance counters; counters saturate at the maximum value.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  a valid instruction is in ID.
- br_type  in  3  branch type: 000 none, 001 BEQ, 010 BNE, 011 BLEZ, 100 BGTZ, 101 BLTZ, 110 BGEZ, 111 reserved (treated as none).
- jmp  in  1  J/JAL.
- jr  in  1  JR/JALR; target is rdata1.
- operands_ready  in  1  forwarded rdata1/rdata2 are valid this cycle.
- rdata1, rdata2  in  D_WIDTH  forwarded register operands.
- pcplus4  in  D_WIDTH  PC+4 of the ID instruction.
- imm  in  16  raw branch offset.
- addr_j  in  26  jump index.
- pred_taken  in  1  IF fetched the branch target (static prediction).
- redir_ready  in  1  fetch unit accepts the redirect.
- id_stall  out  1  hold PC and IF/ID this cycle.
- flush_ifid  out  1  one-cycle pulse; invalidate the IF/ID entry.
- redir_valid  out  1  redirect request.
- redir_pc  out  D_WIDTH  redirect target.
- brn_cnt, taken_cnt, mispred_cnt  out  CNT_W each  performance counters.

Behaviour:
- Control instruction (ctrl): id_valid && (br_type in 001..110 || jmp || jr). Priority is jr > jmp > br_type.
- needs_ops: ctrl && (jr || branch). A direct jmp never waits for operands.
- Conditions, signed compare on rdata1 (rdata2 for BEQ/BNE):
  - BEQ: rdata1 == rdata2. BNE: rdata1 != rdata2.
  - BLEZ: rdata1 <= 0. BGTZ: rdata1 > 0.
  - BLTZ: rdata1 < 0. BGEZ: rdata1 >= 0.
- Targets:
  - Branch: pcplus4 + (sign_extend(imm) << 2), modulo 2^D_WIDTH.
  - J: {pcplus4[D_WIDTH-1:28], addr_j, 2'b00}.
  - JR: rdata1.
  - Branch fall-through (predicted taken, actually not taken): pcplus4.
- Redirect decision:
  - jmp/jr: always redirect.
  - Branch: redirect iff taken != pred_taken.
  - A correctly predicted branch causes no redirect and no stall.
- FSM states: IDLE, REDIRECT.
- IDLE:
  - id_stall = needs_ops && !operands_ready. The unit re-evaluates every cycle with fresh forwarded values and takes no action while stalled.
  - Resolve when ctrl && (!needs_ops || operands_ready).
  - On a resolve needing a redirect, the next edge loads redir_pc, sets redir_valid=1, pulses flush_ifid=1 for exactly one cycle, and moves to REDIRECT.
- REDIRECT:
  - id_stall=1; redir_valid and redir_pc are held stable.
  - On redir_ready=1, the next edge clears redir_valid and returns to IDLE.
  - ctrl inputs are ignored because the ID contents are wrong-path.
  - Minimum redirect latency: 1 cycle from resolve to redir_valid. Redirect occupancy is 1 + (cycles until redir_ready).
  - redir_ready high while redir_valid=0 is ignored.
- Counters (updated at the resolve edge):
  - brn_cnt increments on each resolved conditional branch.
  - taken_cnt increments on each taken branch.
  - mispred_cnt increments on each branch redirect. Jumps are not counted.
  - All counters saturate at 2^CNT_W-1.
- Reset: state=IDLE, redir_valid=0, redir_pc=0, flush_ifid=0, all counters=0.
  - Reset asserted in REDIRECT abandons the redirect; redir_valid is 0 after the edge.
  - id_stall is 0 during reset.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined: the counters behave as specified above.
- Undefined: no counter registers are built; brn_cnt, taken_cnt and mispred_cnt are tied to 0. All other behaviour is identical.

Decomposition:
- Package bru_pkg: br_type encodings (BR_NONE, BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ), FSM state encoding.
- One combinational sub-module, branch_cond_eval: takes br_type, rdata1 and rdata2; produces taken.

Test Plan:
- BEQ, rdata1=rdata2=5, imm=16'h0004, pcplus4=0x100, pred_taken=0 -> redir_valid next cycle, redir_pc=0x110, flush_ifid one cycle, mispred_cnt=1.
- BNE taken with pred_taken=1, imm=16'hFFFE, pcplus4=0x200 -> no redirect, no stall; taken_cnt=1. Then BGEZ with rdata1=0xFFFFFFFF and pred_taken=1 -> redir_pc=pcplus4.
- J with addr_j=26'h0000040, pcplus4=0x40000004 -> redir_pc=0x40000100. Hold redir_ready=0 for 3 cycles -> redir_valid and id_stall stay high, redir_pc stable.
- JR with operands_ready=0 for 2 cycles, then rdata1=0x8000 -> id_stall high for 2 cycles, then redir_pc=0x8000.
- rst asserted while in REDIRECT -> redir_valid=0 and counters=0 after the edge; next BLEZ with rdata1=0 resolves normally.
- BRU_PERF_CNT_EN undefined: rerun scenario 1 -> identical redirect, all counters read 0. With the macro defined and CNT_W=2, five mispredicts -> mispred_cnt=3.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared encodings for the branch resolve unit: branch types and FSM states.
package bru_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'b000,
      BR_BEQ  = 3'b001,
      BR_BNE  = 3'b010,
      BR_BLEZ = 3'b011,
      BR_BGTZ = 3'b100,
      BR_BLTZ = 3'b101,
      BR_BGEZ = 3'b110,
      BR_RSVD = 3'b111
   } br_type_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } bru_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: signed tests on rdata1 (rdata1 vs rdata2 for BEQ/BNE).
// Zero latency; reserved/none encodings never report taken.
module branch_cond_eval #(
   parameter int D_WIDTH = 32
) (
   input  logic [2:0]         br_type_i,
   input  logic [D_WIDTH-1:0] rdata1_i,
   input  logic [D_WIDTH-1:0] rdata2_i,
   output logic               taken_o
);
   import bru_pkg::*;

   logic is_neg;
   logic is_zero;
   logic is_eq;

   assign is_neg  = rdata1_i[D_WIDTH-1];
   assign is_zero = (rdata1_i == '0);
   assign is_eq   = (rdata1_i == rdata2_i);

   always_comb begin
      taken_o = 1'b0;
      case (br_type_i)
         BR_BEQ:  taken_o = is_eq;
         BR_BNE:  taken_o = !is_eq;
         BR_BLEZ: taken_o = is_neg || is_zero;
         BR_BGTZ: taken_o = !is_neg && !is_zero;
         BR_BLTZ: taken_o = is_neg;
         BR_BGEZ: taken_o = !is_neg;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch/jump resolver: redirect registered 1 cycle after resolve, held until redir_ready_i.
// BRU_PERF_CNT_EN builds the saturating perf counters; otherwise they read 0.
module branch_resolve_unit #(
   parameter int D_WIDTH = 32,
   parameter int CNT_W   = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               id_valid_i,
   input  logic [2:0]         br_type_i,
   input  logic               jmp_i,
   input  logic               jr_i,
   input  logic               operands_ready_i,
   input  logic [D_WIDTH-1:0] rdata1_i,
   input  logic [D_WIDTH-1:0] rdata2_i,
   input  logic [D_WIDTH-1:0] pcplus4_i,
   input  logic [15:0]        imm_i,
   input  logic [25:0]        addr_j_i,
   input  logic               pred_taken_i,
   input  logic               redir_ready_i,
   output logic               id_stall_o,
   output logic               flush_ifid_o,
   output logic               redir_valid_o,
   output logic [D_WIDTH-1:0] redir_pc_o,
   output logic [CNT_W-1:0]   brn_cnt_o,
   output logic [CNT_W-1:0]   taken_cnt_o,
   output logic [CNT_W-1:0]   mispred_cnt_o
);
   import bru_pkg::*;

   bru_state_e         state_q, state_d;
   logic [D_WIDTH-1:0] redir_pc_q, redir_pc_d;
   logic               flush_q, flush_d;
   logic               stall_d;

   logic               is_jr, is_jmp, is_br;
   logic               ctrl, needs_ops, resolve_now;
   logic               taken, br_mispred, need_redir;
   logic [D_WIDTH-1:0] br_target, j_target, j_mask, target;

   // Decode with priority jr > jmp > br_type.
   assign is_jr     = id_valid_i && jr_i;
   assign is_jmp    = id_valid_i && !jr_i && jmp_i;
   assign is_br     = id_valid_i && !jr_i && !jmp_i &&
                      (br_type_i != BR_NONE) && (br_type_i != BR_RSVD);
   assign ctrl      = is_jr || is_jmp || is_br;
   assign needs_ops = is_jr || is_br;

   assign resolve_now = (state_q == ST_IDLE) && ctrl && (!needs_ops || operands_ready_i);

   branch_cond_eval #(
      .D_WIDTH (D_WIDTH)
   ) u_cond (
      .br_type_i (br_type_i),
      .rdata1_i  (rdata1_i),
      .rdata2_i  (rdata2_i),
      .taken_o   (taken)
   );

   assign br_mispred = is_br && (taken != pred_taken_i);
   assign need_redir = is_jr || is_jmp || br_mispred;

   assign br_target = pcplus4_i + {{(D_WIDTH-18){imm_i[15]}}, imm_i, 2'b00};
   // Mask form keeps the J target legal even at the minimum width of 28.
   assign j_mask    = {D_WIDTH{1'b1}} << 28;
   assign j_target  = (pcplus4_i & j_mask) | D_WIDTH'({addr_j_i, 2'b00});

   always_comb begin
      target = pcplus4_i;
      if (is_jr)       target = rdata1_i;
      else if (is_jmp) target = j_target;
      else if (taken)  target = br_target;
   end

   always_comb begin
      state_d    = state_q;
      redir_pc_d = redir_pc_q;
      flush_d    = 1'b0;
      stall_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stall_d = needs_ops && !operands_ready_i;
            if (resolve_now && need_redir) begin
               state_d    = ST_REDIRECT;
               redir_pc_d = target;
               flush_d    = 1'b1;
            end
         end
         ST_REDIRECT: begin
            // ID holds wrong-path contents here, so its ctrl inputs are ignored.
            stall_d = 1'b1;
            if (redir_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         redir_pc_q <= '0;
         flush_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         redir_pc_q <= redir_pc_d;
         flush_q    <= flush_d;
      end
   end

   assign id_stall_o    = stall_d && !rst_i;
   assign flush_ifid_o  = flush_q;
   assign redir_valid_o = (state_q == ST_REDIRECT);
   assign redir_pc_o    = redir_pc_q;

`ifdef BRU_PERF_CNT_EN
   logic [CNT_W-1:0] brn_cnt_q, taken_cnt_q, mispred_cnt_q;
   logic             br_resolve;

   assign br_resolve = resolve_now && is_br;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         brn_cnt_q     <= '0;
         taken_cnt_q   <= '0;
         mispred_cnt_q <= '0;
      end else if (br_resolve) begin
         if (brn_cnt_q != '1)                  brn_cnt_q     <= brn_cnt_q + CNT_W'(1);
         if (taken && taken_cnt_q != '1)       taken_cnt_q   <= taken_cnt_q + CNT_W'(1);
         if (br_mispred && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
   end

   assign brn_cnt_o     = brn_cnt_q;
   assign taken_cnt_o   = taken_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;
`else
   assign brn_cnt_o     = '0;
   assign taken_cnt_o   = '0;
   assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; counters built narrow (CNT_W=2) to reach saturation.
module tb_branch_resolve_unit;

   localparam int DW = 32;
   localparam int CW = 2;
`ifdef BRU_PERF_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [2:0]    br_type;
   logic          jmp, jr, operands_ready;
   logic [DW-1:0] rdata1, rdata2, pcplus4;
   logic [15:0]   imm;
   logic [25:0]   addr_j;
   logic          pred_taken, redir_ready;
   logic          id_stall, flush_ifid, redir_valid;
   logic [DW-1:0] redir_pc;
   logic [CW-1:0] brn_cnt, taken_cnt, mispred_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.D_WIDTH(DW), .CNT_W(CW)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .id_valid_i       (id_valid),
      .br_type_i        (br_type),
      .jmp_i            (jmp),
      .jr_i             (jr),
      .operands_ready_i (operands_ready),
      .rdata1_i         (rdata1),
      .rdata2_i         (rdata2),
      .pcplus4_i        (pcplus4),
      .imm_i            (imm),
      .addr_j_i         (addr_j),
      .pred_taken_i     (pred_taken),
      .redir_ready_i    (redir_ready),
      .id_stall_o       (id_stall),
      .flush_ifid_o     (flush_ifid),
      .redir_valid_o    (redir_valid),
      .redir_pc_o       (redir_pc),
      .brn_cnt_o        (brn_cnt),
      .taken_cnt_o      (taken_cnt),
      .mispred_cnt_o    (mispred_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input int b, input int t, input int m);
      chk({tag, ".brn"},     32'(brn_cnt),     CNT_ON ? 32'(b) : 32'd0);
      chk({tag, ".taken"},   32'(taken_cnt),   CNT_ON ? 32'(t) : 32'd0);
      chk({tag, ".mispred"}, 32'(mispred_cnt), CNT_ON ? 32'(m) : 32'd0);
   endtask

   task automatic idle_in();
      id_valid = 0; br_type = 3'b000; jmp = 0; jr = 0; operands_ready = 0;
      rdata1 = '0; rdata2 = '0; pcplus4 = '0; imm = '0; addr_j = '0; pred_taken = 0;
   endtask

   task automatic br_in(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [15:0] im, input logic p);
      idle_in();
      id_valid = 1; br_type = t; rdata1 = a; rdata2 = b; pcplus4 = pc; imm = im;
      pred_taken = p; operands_ready = 1;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      idle_in();
      redir_ready = 0;
      rst = 1;
      // JR waiting on operands during reset must not stall.
      id_valid = 1; jr = 1;
      adv(); adv();
      mid();
      chk("rst.stall", 32'(id_stall), 0);
      idle_in();
      rst = 0;
      adv();
      mid();
      chk("rst.valid", 32'(redir_valid), 0);
      chk("rst.flush", 32'(flush_ifid), 0);
      chk("rst.pc", redir_pc, 0);
      chk_cnt("rst", 0, 0, 0);

      // BEQ taken, predicted not taken.
      adv();
      br_in(3'b001, 32'd5, 32'd5, 32'h100, 16'h0004, 0);
      mid();
      chk("beq.stall0", 32'(id_stall), 0);
      chk("beq.valid0", 32'(redir_valid), 0);
      adv();
      idle_in();
      mid();
      chk("beq.valid", 32'(redir_valid), 1);
      chk("beq.pc", redir_pc, 32'h110);
      chk("beq.flush", 32'(flush_ifid), 1);
      chk("beq.stall", 32'(id_stall), 1);
      chk_cnt("beq", 1, 1, 1);
      adv();
      mid();
      chk("beq.flush_end", 32'(flush_ifid), 0);
      chk("beq.valid_hold", 32'(redir_valid), 1);
      redir_ready = 1;
      adv();
      redir_ready = 0;
      mid();
      chk("beq.valid_clr", 32'(redir_valid), 0);

      // BNE taken, correctly predicted: no redirect, no stall.
      br_in(3'b010, 32'd1, 32'd2, 32'h200, 16'hFFFE, 1);
      mid();
      chk("bne.stall", 32'(id_stall), 0);
      adv();
      // Reserved encoding is not a branch: no stall even without operands.
      idle_in();
      id_valid = 1; br_type = 3'b111;
      mid();
      chk("bne.valid", 32'(redir_valid), 0);
      chk("bne.flush", 32'(flush_ifid), 0);
      chk("rsvd.stall", 32'(id_stall), 0);
      chk_cnt("bne", 2, 2, 1);
      adv();
      mid();
      chk("rsvd.valid", 32'(redir_valid), 0);

      // BGEZ on -1, predicted taken: fall through to pcplus4.
      br_in(3'b110, 32'hFFFF_FFFF, 32'd0, 32'h300, 16'h0010, 1);
      adv();
      idle_in();
      mid();
      chk("bgez.valid", 32'(redir_valid), 1);
      chk("bgez.pc", redir_pc, 32'h300);
      chk_cnt("bgez", 3, 2, 2);
      redir_ready = 1;
      adv();
      redir_ready = 0;

      // J with fetch unit stalling the redirect for 3 cycles.
      idle_in();
      id_valid = 1; jmp = 1; addr_j = 26'h0000040; pcplus4 = 32'h4000_0004;
      adv();
      // Wrong-path jump in ID while redirecting must be ignored.
      addr_j = 26'h3FFFFFF; pcplus4 = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("j.valid", 32'(redir_valid), 1);
         chk("j.stall", 32'(id_stall), 1);
         chk("j.pc", redir_pc, 32'h4000_0100);
         adv();
      end
      mid();
      chk_cnt("j", 3, 2, 2);
      idle_in();
      redir_ready = 1;
      adv();
      redir_ready = 0;
      mid();
      chk("j.valid_clr", 32'(redir_valid), 0);
      chk("j.stall_clr", 32'(id_stall), 0);

      // JR waiting two cycles for forwarded operands.
      idle_in();
      id_valid = 1; jr = 1; rdata1 = 32'h1234;
      for (int i = 0; i < 2; i++) begin
         mid();
         chk("jr.stall", 32'(id_stall), 1);
         chk("jr.valid0", 32'(redir_valid), 0);
         adv();
      end
      operands_ready = 1; rdata1 = 32'h8000;
      mid();
      chk("jr.stall_rel", 32'(id_stall), 0);
      adv();
      idle_in();
      mid();
      chk("jr.valid", 32'(redir_valid), 1);
      chk("jr.pc", redir_pc, 32'h8000);

      // Reset while in REDIRECT abandons it.
      rst = 1;
      mid();
      chk("rst2.stall", 32'(id_stall), 0);
      adv();
      rst = 0;
      mid();
      chk("rst2.valid", 32'(redir_valid), 0);
      chk("rst2.pc", redir_pc, 0);
      chk_cnt("rst2", 0, 0, 0);

      // BLEZ on 0: taken, predicted not taken.
      br_in(3'b011, 32'd0, 32'd0, 32'h500, 16'h0010, 0);
      adv();
      idle_in();
      mid();
      chk("blez.valid", 32'(redir_valid), 1);
      chk("blez.pc", redir_pc, 32'h540);
      chk_cnt("blez", 1, 1, 1);
      redir_ready = 1;
      adv();

      // Five not-taken BEQ mispredicts saturate the 2-bit counters;
      // redir_ready stays high, so it is also seen while idle.
      for (int i = 0; i < 5; i++) begin
         br_in(3'b001, 32'd1, 32'd2, 32'h600 + 32'(i) * 32'h10, 16'h0004, 1);
         adv();
         idle_in();
         mid();
         chk("sat.valid", 32'(redir_valid), 1);
         chk("sat.pc", redir_pc, 32'h600 + 32'(i) * 32'h10);
         adv();
      end
      mid();
      chk("sat.valid_clr", 32'(redir_valid), 0);
      chk_cnt("sat", 3, 1, 3);
      redir_ready = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
